// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder: DIGIT bits per clock through one slice and a carry flop.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] ps_next;
    logic             last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        slice   = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};
        // New digit enters at the MSB end so the final digit lands in the top slot.
        ps_next = (ps_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        last    = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == RUN) begin
            a_sh_d  = a_sh_q >> DIGIT;
            b_sh_d  = b_sh_q >> DIGIT;
            ps_d    = ps_next;
            carry_d = slice[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
                sum_d  = ps_next;
                cout_d = slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into the MSB is recovered from the MSB sum bit of the top digit.
                ovf_d  = slice[DIGIT] ^ (a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1] ^ slice[DIGIT-1]);
`endif
            end
        end else if (start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            ps_d    = '0;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (8x1 and 16x4 instances).
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start8 = 1'b0, cin8 = 1'b0, cout8, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;
    logic        start16 = 1'b0, cin16 = 1'b0, cout16, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        ovf8, ovf16;

    int checks = 0;
    int errors = 0;
    logic [9:0]  q8[$];
    logic [17:0] q16[$];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .cout(cout16), .busy(busy16), .done(done16)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf8  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    function automatic logic [9:0] model8(logic [7:0] a, logic [7:0] b, logic c);
        int u = int'(a) + int'(b) + int'(c);
        int s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return {(s > 127 || s < -128), u[8:0]};
    endfunction

    function automatic logic [17:0] model16(logic [15:0] a, logic [15:0] b, logic c);
        int u = int'(a) + int'(b) + int'(c);
        int s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return {(s > 32767 || s < -32768), u[16:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(model8(a, b, c));
        step();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("busy8_after_capture", 32'(busy8), 32'd1);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        q16.push_back(model16(a, b, c));
        step();
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        check("busy16_after_capture", 32'(busy16), 32'd1);
    endtask

    task automatic wait8(input int exp_lat);
        int n = 0;
        while (!done8 && n < 100) begin step(); n++; end
        check("latency8", 32'(n), 32'(exp_lat));
    endtask

    task automatic wait16(input int exp_lat);
        int n = 0;
        while (!done16 && n < 100) begin step(); n++; end
        check("latency16", 32'(n), 32'(exp_lat));
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e[7:0]));
                check("cout8", 32'(cout8), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf8", 32'(ovf8), 32'(e[9]));
`endif
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        if (done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check("sum16", 32'(sum16), 32'(e[15:0]));
                check("cout16", 32'(cout16), 32'(e[16]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf16", 32'(ovf16), 32'(e[17]));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with start asserted must not enter RUN.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        step(); step();
        rst = 1'b0; start8 = 1'b0;
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        step();
        check("rst_busy8_later", 32'(busy8), 32'd0);

        issue8(8'h5A, 8'h3C, 1'b0); wait8(8);
        step();
        issue8(8'hFF, 8'h01, 1'b0); wait8(8);
        step();
        issue8(8'hFF, 8'hFF, 1'b1); wait8(8);
        step();

        // Start while busy is ignored; result registers hold the old add.
        issue8(8'h5A, 8'h3C, 1'b0);
        step(); step();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        step();
        start8 = 1'b0;
        check("hold_sum8", 32'(sum8), 32'hFF);
        check("hold_cout8", 32'(cout8), 32'd1);
        wait8(5);
        repeat (12) step();

        // Back-to-back: second add is captured during the DONE cycle.
        issue8(8'h7F, 8'h01, 1'b0); wait8(8);
        issue8(8'h10, 8'h20, 1'b0); wait8(8);
        step();

        // Abort mid-run with reset.
        issue8(8'hA5, 8'h5A, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q8.delete();
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_sum8", 32'(sum8), 32'd0);
        check("abort_cout8", 32'(cout8), 32'd0);
        repeat (12) step();
        issue8(8'h33, 8'h44, 1'b0); wait8(8);
        step();

        for (int i = 0; i < 20; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            wait8(8);
            repeat ($urandom_range(0, 2)) step();
        end
        step();

        issue16(16'h1234, 16'hFFFF, 1'b0); wait16(4);
        issue16(16'h7FFF, 16'h0001, 1'b0); wait16(4);
        for (int i = 0; i < 15; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom));
            wait16(4);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (12) step();
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
